// File: rtl/rv32i_pkg.sv
// Shared RV32I types: decoded control bundle, ALU/writeback selectors, widths.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 12;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    // MSB-first: alu_op[11:8] alu_src[7] mem_read[6] mem_write[5] reg_write[4] wb_sel[3:2] branch[1] jump[0]
    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        wb_sel_e wb_sel;
        logic    branch;
        logic    jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/operand_fwd.sv
// Per-source operand select: x0 guard, then EX > MEM > WB forwarding, else register file data.
module operand_fwd
    import rv32i_pkg::*;
#(
    parameter int DataWidth    = XLEN,
    parameter int AddrRegWidth = REG_AW
) (
    input  logic [AddrRegWidth-1:0] idx,
    input  logic                    ex_en,
    input  logic [AddrRegWidth-1:0] ex_rd,
    input  logic [DataWidth-1:0]    ex_data,
    input  logic                    mem_en,
    input  logic [AddrRegWidth-1:0] mem_rd,
    input  logic [DataWidth-1:0]    mem_data,
    input  logic                    wb_en,
    input  logic [AddrRegWidth-1:0] wb_rd,
    input  logic [DataWidth-1:0]    wb_data,
    input  logic [DataWidth-1:0]    rdata,
    output logic [DataWidth-1:0]    value
);

    always_comb begin
        value = rdata;
        if (idx == '0) begin
            value = '0;
        end else if (ex_en && (ex_rd == idx)) begin
            value = ex_data;
        end else if (mem_en && (mem_rd == idx)) begin
            value = mem_data;
        end else if (wb_en && (wb_rd == idx)) begin
            value = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding, load-use stall detection,
// flush/hazard bubbles and global freeze.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddrRegWidth = 5,
    parameter int CtrlWidth    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [DataWidth-1:0]    id_pc,
    input  logic [AddrRegWidth-1:0] id_rs1,
    input  logic [AddrRegWidth-1:0] id_rs2,
    input  logic [AddrRegWidth-1:0] id_rd,
    input  logic [DataWidth-1:0]    id_imm,
    input  logic [CtrlWidth-1:0]    id_ctrl,
    input  logic [DataWidth-1:0]    id_rdata1,
    input  logic [DataWidth-1:0]    id_rdata2,
    input  logic [DataWidth-1:0]    ex_fwd_data,
    input  logic [AddrRegWidth-1:0] mem_rd,
    input  logic [AddrRegWidth-1:0] wb_rd,
    input  logic                    mem_reg_write,
    input  logic                    wb_reg_write,
    input  logic [DataWidth-1:0]    mem_fwd_data,
    input  logic [DataWidth-1:0]    wb_fwd_data,
    input  logic                    stall_in,
    input  logic                    flush,
    output logic                    id_stall,
    output logic                    ex_valid,
    output logic [DataWidth-1:0]    ex_pc,
    output logic [DataWidth-1:0]    ex_imm,
    output logic [DataWidth-1:0]    ex_rs1_val,
    output logic [DataWidth-1:0]    ex_rs2_val,
    output logic [AddrRegWidth-1:0] ex_rd,
    output logic [CtrlWidth-1:0]    ex_ctrl
);

    logic                    ex_valid_reg;
    logic [DataWidth-1:0]    ex_pc_reg;
    logic [DataWidth-1:0]    ex_imm_reg;
    logic [DataWidth-1:0]    ex_rs1_reg;
    logic [DataWidth-1:0]    ex_rs2_reg;
    logic [AddrRegWidth-1:0] ex_rd_reg;
    ctrl_t                   ex_ctrl_reg;

    ctrl_t id_ctrl_s;
    logic  hazard;
    logic  ex_fwd_en;

    logic [AddrRegWidth-1:0] src_idx   [2];
    logic [DataWidth-1:0]    src_rdata [2];
    logic [DataWidth-1:0]    src_value [2];

    assign id_ctrl_s = ctrl_t'(id_ctrl);

    // A load in EX has no data yet: it cannot forward and forces a stall on use.
    assign ex_fwd_en = ex_valid_reg & ex_ctrl_reg.reg_write & ~ex_ctrl_reg.mem_read;
    assign hazard    = ex_valid_reg & ex_ctrl_reg.mem_read & (ex_rd_reg != '0) & id_valid
                     & ((ex_rd_reg == id_rs1) | (ex_rd_reg == id_rs2));
    assign id_stall  = hazard & ~flush & ~stall_in;

    assign src_idx[0]   = id_rs1;
    assign src_idx[1]   = id_rs2;
    assign src_rdata[0] = id_rdata1;
    assign src_rdata[1] = id_rdata2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            operand_fwd #(
                .DataWidth    (DataWidth),
                .AddrRegWidth (AddrRegWidth)
            ) u_operand_fwd (
                .idx      (src_idx[gi]),
                .ex_en    (ex_fwd_en),
                .ex_rd    (ex_rd_reg),
                .ex_data  (ex_fwd_data),
                .mem_en   (mem_reg_write),
                .mem_rd   (mem_rd),
                .mem_data (mem_fwd_data),
                .wb_en    (wb_reg_write),
                .wb_rd    (wb_rd),
                .wb_data  (wb_fwd_data),
                .rdata    (src_rdata[gi]),
                .value    (src_value[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || (!stall_in && (flush || hazard))) begin
            ex_valid_reg <= 1'b0;
            ex_pc_reg    <= '0;
            ex_imm_reg   <= '0;
            ex_rs1_reg   <= '0;
            ex_rs2_reg   <= '0;
            ex_rd_reg    <= '0;
            ex_ctrl_reg  <= CTRL_NOP;
        end else if (!stall_in) begin
            ex_valid_reg <= id_valid;
            ex_pc_reg    <= id_pc;
            ex_imm_reg   <= id_imm;
            ex_rs1_reg   <= src_value[0];
            ex_rs2_reg   <= src_value[1];
            ex_rd_reg    <= id_rd;
            ex_ctrl_reg  <= id_valid ? id_ctrl_s : CTRL_NOP;
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_pc      = ex_pc_reg;
    assign ex_imm     = ex_imm_reg;
    assign ex_rs1_val = ex_rs1_reg;
    assign ex_rs2_val = ex_rs2_reg;
    assign ex_rd      = ex_rd_reg;
    assign ex_ctrl    = ex_ctrl_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hand sequences,
// expectations queued at drive time and compared one cycle later.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm;
    logic [11:0] id_ctrl;
    logic [31:0] id_rdata1, id_rdata2;
    logic [31:0] ex_fwd_data;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        stall_in, flush;
    logic        id_stall, ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rd;
    logic [11:0] ex_ctrl;

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_imm        (id_imm),
        .id_ctrl       (id_ctrl),
        .id_rdata1     (id_rdata1),
        .id_rdata2     (id_rdata2),
        .ex_fwd_data   (ex_fwd_data),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_data   (wb_fwd_data),
        .stall_in      (stall_in),
        .flush         (flush),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1_val    (ex_rs1_val),
        .ex_rs2_val    (ex_rs2_val),
        .ex_rd         (ex_rd),
        .ex_ctrl       (ex_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control encodings: ALU add/sll with reg_write, and lw (mem_read, reg_write, wb=MEM).
    localparam logic [31:0] C_ALU = 32'h210;
    localparam logic [31:0] C_LW  = 32'h054;

    typedef struct {
        logic [31:0] valid, pc, rs1, rs2, rd, imm, ctrl, rd1, rd2, exf;
        logic [31:0] mrd, mwe, md, wrd, wwe, wd, sti, fl, rst;
        logic [31:0] e_stall, e_valid, e_ctrl, e_rd, e_pc, e_imm, e_r1, e_r2;
    } vec_t;

    vec_t tbl [11];
    vec_t sb [$];
    vec_t h;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst[0];
        id_valid      = v.valid[0];
        id_pc         = v.pc;
        id_rs1        = v.rs1[4:0];
        id_rs2        = v.rs2[4:0];
        id_rd         = v.rd[4:0];
        id_imm        = v.imm;
        id_ctrl       = v.ctrl[11:0];
        id_rdata1     = v.rd1;
        id_rdata2     = v.rd2;
        ex_fwd_data   = v.exf;
        mem_rd        = v.mrd[4:0];
        mem_reg_write = v.mwe[0];
        mem_fwd_data  = v.md;
        wb_rd         = v.wrd[4:0];
        wb_reg_write  = v.wwe[0];
        wb_fwd_data   = v.wd;
        stall_in      = v.sti[0];
        flush         = v.fl[0];
    endtask

    task automatic compare_out(input string tag, input vec_t e);
        chk({tag, ".ex_valid"}, {31'b0, ex_valid}, e.e_valid);
        chk({tag, ".ex_ctrl"}, {20'b0, ex_ctrl}, e.e_ctrl);
        chk({tag, ".ex_rd"}, {27'b0, ex_rd}, e.e_rd);
        chk({tag, ".ex_pc"}, ex_pc, e.e_pc);
        chk({tag, ".ex_imm"}, ex_imm, e.e_imm);
        chk({tag, ".ex_rs1_val"}, ex_rs1_val, e.e_r1);
        chk({tag, ".ex_rs2_val"}, ex_rs2_val, e.e_r2);
    endtask

    // Called at posedge+1: drive, check combinational id_stall, clock, pop and compare.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        drive(v);
        sb.push_back(v);
        #3;
        chk({tag, ".id_stall"}, {31'b0, id_stall}, v.e_stall);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare_out(tag, e);
        $display("step %s: valid=%0b ctrl=0x%0h rd=%0d pc=0x%0h rs1v=0x%0h rs2v=0x%0h",
                 tag, ex_valid, ex_ctrl, ex_rd, ex_pc, ex_rs1_val, ex_rs2_val);
    endtask

    initial begin
        //          v  pc     rs1 rs2 rd imm    ctrl   rd1      rd2      exf      mrd mwe md       wrd wwe wd       sti fl rst | es ev ectl   erd epc    eimm   er1      er2
        tbl[0]  = '{1, 'h100, 5, 6, 7, 'h10, C_ALU, 'h11,    'h22,    0,       0, 0, 0,       0, 0, 0,       0, 0, 0,  0, 1, C_ALU, 7, 'h100, 'h10, 'h11,    'h22};
        tbl[1]  = '{1, 'h104, 7, 0, 8, 'h14, C_ALU, 'h99,    'h55,    'hAA,    7, 1, 'hBB,    7, 1, 'hCC,    0, 0, 0,  0, 1, C_ALU, 8, 'h104, 'h14, 'hAA,    0};
        tbl[2]  = '{1, 'h108, 7, 0, 9, 'h18, C_ALU, 'h99,    'h55,    'hAA,    7, 1, 'hBB,    7, 1, 'hCC,    0, 0, 0,  0, 1, C_ALU, 9, 'h108, 'h18, 'hBB,    0};
        tbl[3]  = '{1, 'h10C, 7, 7, 0, 'h1C, C_ALU, 'h99,    'h55,    'hAA,    7, 0, 'hBB,    7, 1, 'hCC,    0, 0, 0,  0, 1, C_ALU, 0, 'h10C, 'h1C, 'hCC,    'hCC};
        tbl[4]  = '{1, 'h110, 0, 0, 3, 'h20, C_LW,  'hDEAD,  'hDEAD,  'hDEAD,  0, 1, 'hDEAD,  0, 1, 'hDEAD,  0, 0, 0,  0, 1, C_LW,  3, 'h110, 'h20, 0,       0};
        tbl[5]  = '{1, 'h114, 1, 3, 4, 'h24, C_ALU, 'h10,    'h30,    0,       0, 0, 0,       0, 0, 0,       0, 0, 0,  1, 0, 0,     0, 0,      0,     0,       0};
        tbl[6]  = '{1, 'h114, 1, 3, 4, 'h24, C_ALU, 'h10,    'h30,    'hEEE,   3, 1, 'h333,   0, 0, 0,       0, 0, 0,  0, 1, C_ALU, 4, 'h114, 'h24, 'h10,    'h333};
        tbl[7]  = '{0, 'h120, 2, 0, 5, 'h28, C_ALU, 'h77,    0,       0,       0, 0, 0,       0, 0, 0,       0, 0, 0,  0, 0, 0,     5, 'h120, 'h28, 'h77,    0};
        tbl[8]  = '{1, 'h124, 0, 0, 6, 'h2C, C_LW,  0,       0,       0,       0, 0, 0,       0, 0, 0,       0, 0, 0,  0, 1, C_LW,  6, 'h124, 'h2C, 0,       0};
        tbl[9]  = '{0, 'h128, 6, 6, 0, 0,    C_ALU, 'h61,    'h62,    'hAAA,   0, 0, 0,       6, 1, 'h666,   0, 0, 0,  0, 0, 0,     0, 'h128, 0,     'h666,   'h666};
        tbl[10] = '{1, 'h200, 0, 0, 3, 'h40, C_LW,  0,       0,       0,       0, 0, 0,       0, 0, 0,       0, 0, 0,  0, 1, C_LW,  3, 'h200, 'h40, 0,       0};

        h = '{default: 0};
        drive(h);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("reset.id_stall", {31'b0, id_stall}, 32'h0);
        @(posedge clk);
        #1;
        compare_out("reset", h);

        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // EX holds lw rd=3 from vec10: flush beats the load-use hazard.
        h = '{default: 0};
        h.valid = 1; h.pc = 'h300; h.rs1 = 3; h.rd = 1; h.ctrl = C_ALU; h.rd1 = 'h5; h.fl = 1;
        step("flush_hazard", h);

        // Reload lw rd=3 as the instruction to be frozen.
        h = '{default: 0};
        h.valid = 1; h.pc = 'h204; h.rs1 = 1; h.rd = 3; h.imm = 'h44; h.ctrl = C_LW; h.rd1 = 'h1234;
        h.e_valid = 1; h.e_ctrl = C_LW; h.e_rd = 3; h.e_pc = 'h204; h.e_imm = 'h44; h.e_r1 = 'h1234;
        step("load_again", h);

        // Freeze for 3 cycles while ID presents a dependent instruction; no stall, nothing moves.
        for (int k = 0; k < 3; k++) begin
            h.pc = 'h400 + k; h.rs1 = 3; h.rs2 = 3; h.rd = 9; h.imm = 'h99; h.ctrl = C_ALU;
            h.rd1 = 'hF0 + k; h.rd2 = 'hF8; h.mrd = 3; h.mwe = 1; h.md = 'h777;
            h.sti = 1; h.fl = k[0];
            step($sformatf("freeze%0d", k), h);
        end

        // Reset while frozen clears everything.
        h.rst = 1;
        h.e_valid = 0; h.e_ctrl = 0; h.e_rd = 0; h.e_pc = 0; h.e_imm = 0; h.e_r1 = 0; h.e_r2 = 0;
        step("reset_in_stall", h);

        // After reset EX is empty, so the dependent instruction is captured without stalling.
        h = '{default: 0};
        h.valid = 1; h.pc = 'h500; h.rs1 = 3; h.rs2 = 4; h.rd = 2; h.imm = 'h8; h.ctrl = C_ALU;
        h.rd1 = 'h31; h.rd2 = 'h41; h.wrd = 4; h.wwe = 1; h.wd = 'h4444;
        h.e_valid = 1; h.e_ctrl = C_ALU; h.e_rd = 2; h.e_pc = 'h500; h.e_imm = 'h8;
        h.e_r1 = 'h31; h.e_r2 = 'h4444;
        step("post_reset", h);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
